// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar ingress batcher.
// Latency: none (types and functions only).
// Backpressure: not applicable.
//
// Contents: destination-width helper, default geometry, per-lane request record.
package xbar_pkg;

  // Number of destination bits needed to address num_ports lanes (at least 1).
  function automatic int dst_w_f(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  localparam int NUM_PORTS_DEF = 4;
  localparam int DATA_W_DEF    = 16;
  localparam int TAG_W_DEF     = 5;

  // One buffered lane request; the top's DATA_W/TAG_W must match these widths.
  typedef struct packed {
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } lane_req_t;

endpackage

// File: rtl/xbar_lane_fifo.sv
// Two-entry synchronous FIFO holding lane requests for one ingress lane.
// Latency: a push at edge t is visible at the head from edge t onward (1 cycle).
// Backpressure: push is ignored when full; no pop-through, caller gates with count.
//
// Ports: clk, rst (sync active-high), push/push_req write side,
//        pop/head read side, count = occupancy 0..2.
module xbar_lane_fifo
  import xbar_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  lane_req_t push_req,
  input  logic      pop,
  output lane_req_t head,
  output logic [1:0] count
);

  lane_req_t  mem_q [2];
  lane_req_t  mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != 2'd2);
    do_pop   = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_req;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/xbar_ingress_batcher.sv
// Ingress batcher: per-lane FIFOs feeding rotating-priority batches whose tags form a full permutation.
// Latency: request pushed at edge t appears on out_* after edge t+1 when uncontended.
// Backpressure: out_valid && !out_ready freezes out_*, pops and rr_ptr; full lanes drop in_ready.
//
// Ports: clk, rst (sync active-high); in_valid/in_ready/in_data/in_tag per lane;
//        out_valid/out_ready batch handshake; out_data/out_tag/out_lane_valid per lane
//        (out_lane_valid=0 marks a filler lane carrying an otherwise unused destination).
module xbar_ingress_batcher
  import xbar_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              in_valid,
  output logic [NUM_PORTS-1:0]              in_ready,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  in_data,
  input  logic [NUM_PORTS-1:0][TAG_W-1:0]   in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  out_data,
  output logic [NUM_PORTS-1:0][TAG_W-1:0]   out_tag,
  output logic [NUM_PORTS-1:0]              out_lane_valid
);

  localparam int DST_W = dst_w_f(NUM_PORTS);

  lane_req_t                       head [NUM_PORTS];
  logic [1:0]                      lane_count [NUM_PORTS];
  logic [NUM_PORTS-1:0]            lane_empty;
  logic [NUM_PORTS-1:0]            pop;

  logic [DST_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic                            out_valid_q, out_valid_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] out_data_q, out_data_d;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  out_tag_q, out_tag_d;
  logic [NUM_PORTS-1:0]            out_lane_valid_q, out_lane_valid_d;

  // Combinational selection / filler working variables.
  logic [NUM_PORTS-1:0]            sel;
  logic [NUM_PORTS-1:0]            claimed;
  logic [NUM_PORTS-1:0]            used;
  logic [DST_W-1:0]                lane_idx;
  logic [DST_W-1:0]                dst;
  logic                            found;
  logic                            issue_en;
  logic                            do_issue;
  logic [NUM_PORTS-1:0][DATA_W-1:0] batch_data;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  batch_tag;
  logic [NUM_PORTS-1:0]            batch_lv;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    lane_req_t push_req;
    logic      push;

    assign push_req    = {in_tag[i], in_data[i]};
    // A full lane refuses even if it pops this cycle (no pop-through).
    assign in_ready[i] = !rst && (lane_count[i] != 2'd2);
    assign push        = in_valid[i] && in_ready[i];
    assign lane_empty[i] = (lane_count[i] == 2'd0);

    xbar_lane_fifo u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_req (push_req),
      .pop      (pop[i]),
      .head     (head[i]),
      .count    (lane_count[i])
    );
  end

  always_comb begin
    sel        = '0;
    claimed    = '0;
    used       = '0;
    lane_idx   = '0;
    dst        = '0;
    found      = 1'b0;
    batch_data = '0;
    batch_tag  = '0;
    batch_lv   = '0;

    // Rotating-priority scan: the first lane (from rr_ptr) to present a
    // destination claims it; later heads wanting the same destination wait.
    for (int k = 0; k < NUM_PORTS; k++) begin
      lane_idx = rr_ptr_q + DST_W'(k);
      dst      = head[lane_idx].tag[DST_W-1:0];
      if (!lane_empty[lane_idx] && !claimed[dst]) begin
        sel[lane_idx] = 1'b1;
        claimed[dst]  = 1'b1;
      end
    end

    // Unselected lanes take the leftover destinations in ascending order so
    // the batch is always a complete permutation for the network.
    used = claimed;
    for (int l = 0; l < NUM_PORTS; l++) begin
      if (sel[l]) begin
        batch_data[l] = head[l].data;
        batch_tag[l]  = head[l].tag;
        batch_lv[l]   = 1'b1;
      end else begin
        found = 1'b0;
        for (int d = 0; d < NUM_PORTS; d++) begin
          if (!found && !used[d]) begin
            batch_tag[l] = TAG_W'(d);
            used[d]      = 1'b1;
            found        = 1'b1;
          end
        end
      end
    end

    issue_en = !out_valid_q || out_ready;
    do_issue = issue_en && (|sel);
    pop      = do_issue ? sel : '0;

    // With nothing to issue the register empties but keeps its old contents.
    out_valid_d      = issue_en ? (|sel) : out_valid_q;
    out_data_d       = do_issue ? batch_data : out_data_q;
    out_tag_d        = do_issue ? batch_tag  : out_tag_q;
    out_lane_valid_d = do_issue ? batch_lv   : out_lane_valid_q;
    rr_ptr_d         = do_issue ? (rr_ptr_q + DST_W'(1)) : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q         <= '0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_tag_q        <= '0;
      out_lane_valid_q <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_tag_q        <= out_tag_d;
      out_lane_valid_q <= out_lane_valid_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_tag        = out_tag_q;
  assign out_lane_valid = out_lane_valid_q;

endmodule

// File: tb/tb_xbar_ingress_batcher.sv
// Testbench for xbar_ingress_batcher: queue-based reference model compared every cycle,
// plus directed literal checks for reset, conflicts, fillers, backpressure, fairness, tags.
module tb_xbar_ingress_batcher;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        in_valid;
  logic [3:0]        in_ready;
  logic [3:0][15:0]  in_data;
  logic [3:0][4:0]   in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [3:0][15:0]  out_data;
  logic [3:0][4:0]   out_tag;
  logic [3:0]        out_lane_valid;

  always #5 clk = ~clk;

  xbar_ingress_batcher #(.NUM_PORTS(4), .DATA_W(16), .TAG_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_tag         (in_tag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_tag        (out_tag),
    .out_lane_valid (out_lane_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Each lane is a plain queue of {tag,data}; the output register is a record.
  logic [20:0]      mq [4][$];
  int               rr = 0;
  logic             m_ov = 1'b0;
  logic [3:0][15:0] m_od = '0;
  logic [3:0][4:0]  m_ot = '0;
  logic [3:0]       m_lv = '0;
  bit               cmp_en = 1'b0;

  always @(posedge clk) begin
    logic [3:0]  acc;
    logic [3:0]  win;
    logic [3:0]  taken;
    logic [20:0] hd;
    int          free_d [$];
    int          l, d;
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      rr   = 0;
      m_ov = 1'b0;
      m_od = '0;
      m_ot = '0;
      m_lv = '0;
    end else begin
      for (int i = 0; i < 4; i++) acc[i] = in_valid[i] && (mq[i].size() < 2);
      if (!m_ov || out_ready) begin
        win   = '0;
        taken = '0;
        for (int k = 0; k < 4; k++) begin
          l = (rr + k) % 4;
          if (mq[l].size() > 0) begin
            hd = mq[l][0];
            d  = int'(hd[17:16]);
            if (!taken[d]) begin
              win[l]   = 1'b1;
              taken[d] = 1'b1;
            end
          end
        end
        if (win != 4'b0) begin
          free_d.delete();
          for (int j = 0; j < 4; j++) if (!taken[j]) free_d.push_back(j);
          for (int j = 0; j < 4; j++) begin
            if (win[j]) begin
              hd      = mq[j].pop_front();
              m_od[j] = hd[15:0];
              m_ot[j] = hd[20:16];
              m_lv[j] = 1'b1;
            end else begin
              m_od[j] = '0;
              m_ot[j] = 5'(free_d.pop_front());
              m_lv[j] = 1'b0;
            end
          end
          rr   = (rr + 1) % 4;
          m_ov = 1'b1;
        end else begin
          m_ov = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) if (acc[i]) mq[i].push_back({in_tag[i], in_data[i]});
    end
    cmp_en = 1'b1;
  end

  // Compare DUT against the model on the falling edge of every cycle.
  always @(negedge clk) begin
    logic [3:0] exp_rdy;
    logic [3:0] mask;
    if (cmp_en) begin
      for (int i = 0; i < 4; i++) exp_rdy[i] = !rst && (mq[i].size() < 2);
      check("m_in_ready", 64'(in_ready), 64'(exp_rdy));
      check("m_out_valid", 64'(out_valid), 64'(m_ov));
      check("m_out_data", 64'(out_data), 64'(m_od));
      check("m_out_tag", 64'(out_tag), 64'(m_ot));
      check("m_out_lane_valid", 64'(out_lane_valid), 64'(m_lv));
      if (out_valid) begin
        mask = '0;
        for (int i = 0; i < 4; i++) mask[out_tag[i][1:0]] = 1'b1;
        check("perm", 64'(mask), 64'(4'hF));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int g0 [12];
  int g3 [12];

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = '0;
    in_tag    = '0;

    // Reset: two edges with all lanes requesting.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_in_ready", 64'(in_ready), 64'(4'b0000));
      check("rst_out_valid", 64'(out_valid), 64'(1'b0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
      check("rst_out_lv", 64'(out_lane_valid), 64'(4'b0000));
    end
    rst      = 1'b0;
    in_valid = 4'b0000;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'(4'b1111));

    // No conflict: lanes 0..3 to dests 3,2,1,0.
    for (int i = 0; i < 4; i++) begin
      in_tag[i]  = 5'(3 - i);
      in_data[i] = 16'h00A0 + 16'(i);
    end
    in_valid = 4'b1111;
    tick();
    in_valid = 4'b0000;
    check("nc_not_yet", 64'(out_valid), 64'(1'b0));
    tick();
    check("nc_valid", 64'(out_valid), 64'(1'b1));
    check("nc_tag", 64'(out_tag), 64'({5'd0, 5'd1, 5'd2, 5'd3}));
    check("nc_data", 64'(out_data), 64'({16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}));
    check("nc_lv", 64'(out_lane_valid), 64'(4'b1111));
    tick();
    check("nc_drain", 64'(out_valid), 64'(1'b0));

    // Reset pulse to bring rr_ptr back to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Conflict plus filler: lanes 0 and 2 both want dest 2.
    in_tag[0] = 5'd2; in_data[0] = 16'h1111;
    in_tag[2] = 5'd2; in_data[2] = 16'h2222;
    in_valid  = 4'b0101;
    tick();
    in_valid = 4'b0000;
    tick();
    check("cf1_valid", 64'(out_valid), 64'(1'b1));
    check("cf1_lv", 64'(out_lane_valid), 64'(4'b0001));
    check("cf1_tag", 64'(out_tag), 64'({5'd3, 5'd1, 5'd0, 5'd2}));
    check("cf1_data", 64'(out_data), 64'({16'h0, 16'h0, 16'h0, 16'h1111}));
    tick();
    check("cf2_valid", 64'(out_valid), 64'(1'b1));
    check("cf2_lv", 64'(out_lane_valid), 64'(4'b0100));
    check("cf2_tag", 64'(out_tag), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
    check("cf2_data", 64'(out_data), 64'({16'h0, 16'h2222, 16'h0, 16'h0}));
    tick();
    check("cf_drain", 64'(out_valid), 64'(1'b0));

    // Full tag passthrough on lane 1.
    in_tag[1]  = 5'b10110;
    in_data[1] = 16'hBEEF;
    in_valid   = 4'b0010;
    tick();
    in_valid = 4'b0000;
    tick();
    check("tp_tag1", 64'(out_tag[1]), 64'(5'b10110));
    check("tp_tag", 64'(out_tag), 64'({5'd3, 5'd1, 5'b10110, 5'd0}));
    check("tp_lv", 64'(out_lane_valid), 64'(4'b0010));
    check("tp_data1", 64'(out_data[1]), 64'(16'hBEEF));
    tick();

    // Backpressure: hold batch A for 3 cycles while lanes fill.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_tag[i]  = 5'(i);
      in_data[i] = 16'h5000 + 16'(i);
    end
    in_valid = 4'b1111;
    tick();
    for (int i = 0; i < 4; i++) in_data[i] = 16'h5010 + 16'(i);
    tick();
    check("bp_a_valid", 64'(out_valid), 64'(1'b1));
    check("bp_a_data", 64'(out_data), 64'({16'h5003, 16'h5002, 16'h5001, 16'h5000}));
    check("bp_rdy_after_a", 64'(in_ready), 64'(4'b1111));
    for (int i = 0; i < 4; i++) in_data[i] = 16'h5020 + 16'(i);
    tick();
    check("bp_hold1_data", 64'(out_data), 64'({16'h5003, 16'h5002, 16'h5001, 16'h5000}));
    check("bp_full_rdy", 64'(in_ready), 64'(4'b0000));
    for (int i = 0; i < 4; i++) in_data[i] = 16'h5030 + 16'(i);
    tick();
    check("bp_hold2_data", 64'(out_data), 64'({16'h5003, 16'h5002, 16'h5001, 16'h5000}));
    check("bp_hold2_tag", 64'(out_tag), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
    check("bp_hold2_valid", 64'(out_valid), 64'(1'b1));
    check("bp_full_rdy2", 64'(in_ready), 64'(4'b0000));
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    check("bp_b_data", 64'(out_data), 64'({16'h5013, 16'h5012, 16'h5011, 16'h5010}));
    check("bp_rdy_back", 64'(in_ready), 64'(4'b1111));
    tick();
    check("bp_c_data", 64'(out_data), 64'({16'h5023, 16'h5022, 16'h5021, 16'h5020}));
    tick();
    check("bp_drain", 64'(out_valid), 64'(1'b0));

    // Fairness: lanes 0 and 3 both always want dest 1.
    in_tag[0] = 5'd1;
    in_tag[3] = 5'd1;
    in_valid  = 4'b1001;
    tick();
    for (int b = 0; b < 12; b++) begin
      in_data[0] = 16'h6000 + 16'(b);
      in_data[3] = 16'h6300 + 16'(b);
      tick();
      check("fair_valid", 64'(out_valid), 64'(1'b1));
      check("fair_one_grant", 64'(out_lane_valid[0] ^ out_lane_valid[3]), 64'(1'b1));
      g0[b] = int'(out_lane_valid[0]);
      g3[b] = int'(out_lane_valid[3]);
    end
    for (int w = 0; w <= 8; w++) begin
      int s0, s3;
      s0 = 0;
      s3 = 0;
      for (int j = 0; j < 4; j++) begin
        s0 += g0[w + j];
        s3 += g3[w + j];
      end
      check("fair_l0_window", 64'(s0 > 0), 64'(1));
      check("fair_l3_window", 64'(s3 > 0), 64'(1));
    end
    in_valid = 4'b0000;
    for (int c = 0; c < 4; c++) tick();

    // Randomized traffic with occasional reset, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) begin
        in_tag[i]  = 5'($urandom);
        in_data[i] = 16'($urandom);
      end
      tick();
    end
    rst       = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xbar_ingress_batcher.md
Name: xbar_ingress_batcher

Overview:
- Upstream feeder for the tag-routed crossbar network (columns of compare/crossover switches).
- Buffers per-lane requests, each carrying data plus a destination tag, and resolves destination conflicts with rotating priority.
- Each issued batch is a complete destination permutation: idle lanes receive the unused destinations, so the downstream network always sees a legal, collision-free tag set.

Parameters:
- NUM_PORTS, 4, lane count; power of two, ≥2.
- DATA_W, 16, payload width per lane.
- TAG_W, 5, tag width per lane. Destination index is tag[DST_W-1:0] with DST_W = $clog2(NUM_PORTS). Requires TAG_W ≥ DST_W.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  [NUM_PORTS]  per-lane request valid.
- in_ready  output  [NUM_PORTS]  per-lane request ready.
- in_data  input  [NUM_PORTS][DATA_W]  per-lane payload.
- in_tag  input  [NUM_PORTS][TAG_W]  per-lane tag.
- out_valid  output  1  batch valid.
- out_ready  input  1  network accepts batch.
- out_data  output  [NUM_PORTS][DATA_W]  batch payload per lane.
- out_tag  output  [NUM_PORTS][TAG_W]  batch tag per lane; destinations always form a permutation.
- out_lane_valid  output  [NUM_PORTS]  1 = real request, 0 = filler lane.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - All lane FIFOs empty; rr_ptr=0.
  - out_valid=0; out_data, out_tag and out_lane_valid all 0.
  - in_ready forced 0 while rst=1.
- Lane FIFO: 2 entries per lane. in_ready[i] = !rst && count[i]<2. There is no pop-through, so a full FIFO never accepts, even when it pops in the same cycle.
- Push: in_valid[i] && in_ready[i] writes {in_tag, in_data} at the posedge.
- Issue condition: issue_en = !out_valid || out_ready.
- Selection (combinational, each cycle):
  - Scan lanes in order rr_ptr, rr_ptr+1, ..., modulo NUM_PORTS.
  - A lane is selected if its FIFO is non-empty and its head destination is not yet claimed by an earlier-scanned lane.
  - A conflicting head is held, not dropped. Only FIFO heads are considered.
- Filler assignment:
  - Unclaimed destinations, in ascending order, go to unselected lanes in ascending lane index.
  - Filler lane: out_tag = destination zero-extended to TAG_W, out_data = 0, out_lane_valid = 0.
- Issue (issue_en && ≥1 lane selected), at the posedge:
  - Register the batch; out_valid=1.
  - Pop the selected lanes.
  - rr_ptr = rr_ptr+1 (wraps at NUM_PORTS).
- Hold: out_valid && !out_ready keeps all out_* stable; no pops; rr_ptr unchanged.
- Drain: issue_en with nothing selected sets out_valid=0; out_* contents are don't-care but must equal their last value.
- Latency: a request pushed at edge t reaches the output at edge t+1 (out_valid visible in cycle t+1 → first possible acceptance at end of cycle t+1) when the output register is free and there is no conflict. Throughput is one batch per cycle.
- Full tag passthrough: for selected lanes, out_tag equals in_tag, including upper bits above DST_W.
- Simultaneous push and pop on the same lane is legal when count<2.
- rst asserted mid-operation discards all buffered and registered requests at that edge.
- Invariant: the destination fields across out_tag are always a permutation of 0..NUM_PORTS-1 whenever out_valid=1.

Decomposition:
- Package xbar_pkg:
  - DST_W derivation function.
  - lane_req_t struct {tag, data}, parameterised via localparams matching the defaults.
- Sub-module xbar_lane_fifo: 2-entry sync FIFO carrying lane_req_t, with push/pop/count, one instance per lane.
- Conflict resolution and filler assignment live in the top module as one always_comb block.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=4'b1111 → in_ready=0, out_valid=0, out_* all 0. Release → in_ready=4'b1111.
- No conflict: lanes 0..3 push dest 3,2,1,0 at edge t, out_ready=1 → out_valid=1 in cycle t+1, out_tag dests {3,2,1,0}, out_lane_valid=4'b1111.
- Conflict plus filler (rr_ptr=0): lane0 dest 2, lane2 dest 2, lanes 1 and 3 idle.
  - Batch 1: lane0 selected; fillers lane1→0, lane2→1, lane3→3; out_lane_valid=4'b0001.
  - Batch 2 (rr_ptr=1): lane2 dest 2; out_lane_valid=4'b0100.
- Backpressure: out_ready=0 for 3 cycles with a batch pending → out_* stable, FIFOs fill to 2, in_ready drops to 0 on full lanes. out_ready=1 → drains at 1 batch/cycle.
- Fairness: lanes 0 and 3 continuously push dest 1 → grants alternate between them within every 4 batches; neither starves.
- Tag passthrough: in_tag=5'b10110 (NUM_PORTS=4, dest 2) → out_tag=5'b10110 on that lane.
